// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit data-memory master.
package lsu_pkg;

  localparam int unsigned DMEM_DEPTH = 2048;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_e;

  // Unsigned sizes exist only for loads; the three reserved codes are always illegal.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: f3_illegal = 1'b0;
      F3_BU, F3_HU:     f3_illegal = we;
      default:          f3_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/half lane extraction for loads and lane merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{addr, 3'b000} +: 8];
  assign half_sel = word[{addr[1], 4'b0000} +: 16];

  always_comb begin
    load_val = '0;
    case (funct3)
      F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_val = {24'h000000, byte_sel};
      F3_HU:   load_val = {16'h0000, half_sel};
      default: load_val = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (funct3[1:0])
      2'b00:   merged[{addr, 3'b000} +: 8]     = wdata[7:0];
      2'b01:   merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_master.sv
// One-at-a-time RV32 load/store initiator for a word-wide data memory; sub-word stores use read-modify-write.
module lsu_dmem_master
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = DMEM_DEPTH,
  parameter int unsigned IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_we,
  input  logic [31:0]      i_req_addr,
  input  logic [2:0]       i_req_funct3,
  input  logic [31:0]      i_req_wdata,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [31:0]      o_rsp_rdata,
  output logic             o_rsp_err,
  output logic [IDX_W-1:0] o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  output logic             o_mem_wren,
  input  logic [31:0]      i_mem_rdata
);

  lsu_state_e       st, nxt;
  logic             a_we;
  logic [IDX_W+1:0] a_addr;
  logic [2:0]       a_f3;
  logic [31:0]      a_wdata;
  logic             req_err, misaligned, out_of_range, accept, req_sw;
  logic [31:0]      load_val, merged;

  assign misaligned   = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0])
                     || ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
  assign out_of_range = {2'b00, i_req_addr[31:2]} >= MEM_DEPTH;
  assign req_err      = misaligned || out_of_range || f3_illegal(i_req_we, i_req_funct3);
  assign req_sw       = i_req_we && (i_req_funct3 == F3_W);
  assign accept       = (st == IDLE) && i_req_valid;

  // Strobes come from the state register alone, so reset in WRITE kills the write at once.
  assign o_req_ready = (st == IDLE);
  assign o_rsp_valid = (st == RESP);
  assign o_mem_wren  = (st == WRITE);
  assign o_mem_addr  = a_addr[IDX_W+1:2];

  lsu_align u_align (
    .word    (i_mem_rdata),
    .addr    (a_addr[1:0]),
    .funct3  (a_f3),
    .wdata   (a_wdata),
    .load_val(load_val),
    .merged  (merged)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) st <= IDLE;
    else         st <= nxt;
  end

  always_comb begin
    nxt = st;
    case (st)
      IDLE: begin
        if (i_req_valid) begin
          if (req_err)     nxt = RESP;
          else if (req_sw) nxt = WRITE;
          else             nxt = READ;
        end
      end
      READ:    nxt = a_we ? WRITE : RESP;
      WRITE:   nxt = RESP;
      RESP:    if (i_rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      a_we        <= 1'b0;
      a_addr      <= '0;
      a_f3        <= '0;
      a_wdata     <= '0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
      o_mem_wdata <= '0;
    end else begin
      if (accept) begin
        a_we        <= i_req_we;
        a_addr      <= i_req_addr[IDX_W+1:0];
        a_f3        <= i_req_funct3;
        a_wdata     <= i_req_wdata;
        o_rsp_rdata <= '0;
        o_rsp_err   <= req_err;
        if (req_sw && !req_err) o_mem_wdata <= i_req_wdata;
      end
      if (st == READ) begin
        if (a_we) o_mem_wdata <= merged;
        else      o_rsp_rdata <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed-vector bench for lsu_dmem_master with a word-array memory model.
module tb_lsu_dmem_master;
  import lsu_pkg::*;

  localparam int unsigned DEPTH = 2048;
  localparam int unsigned IW    = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0]   req_addr = '0, req_wdata = '0;
  logic [2:0]    req_f3 = '0;
  logic          req_ready, rsp_valid, rsp_err, mem_wren;
  logic [31:0]   rsp_rdata, mem_wdata, mem_rdata;
  logic [IW-1:0] mem_addr;

  logic [31:0]   mem [DEPTH];
  logic          bk_we = 1'b0;
  logic [IW-1:0] bk_addr = '0;
  logic [31:0]   bk_data = '0;

  int n_checks = 0;
  int n_errors = 0;
  int unstable = 0;

  int          lat, wrens, wcyc;
  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wren)   mem[mem_addr] <= mem_wdata;
    else if (bk_we) mem[bk_addr]  <= bk_data;
  end

  lsu_dmem_master #(.MEM_DEPTH(DEPTH), .IDX_W(IW)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_funct3(req_f3),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_wren  (mem_wren),
    .i_mem_rdata (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic poke(input int unsigned idx, input logic [31:0] data);
    @(negedge clk);
    bk_we = 1'b1; bk_addr = IW'(idx); bk_data = data;
    @(posedge clk); #1;
    bk_we = 1'b0;
  endtask

  // Issues one request, measures accept-to-response latency and write strobes,
  // optionally stalls the response for `hold` cycles, then consumes it.
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd, input int hold,
                         output int o_lat, output int o_wrens, output int o_wcyc,
                         output logic [31:0] o_rd, output logic o_er);
    int cyc;
    o_lat = -1; o_wrens = 0; o_wcyc = -1;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_f3 = f3; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 10) begin
      if (mem_wren) begin o_wrens++; o_wcyc = cyc; end
      @(posedge clk); #1;
      cyc++;
    end
    if (rsp_valid) o_lat = cyc;
    o_rd = rsp_rdata;
    o_er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_rdata !== o_rd || rsp_err !== o_er || req_ready || mem_wren) unstable++;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("idle_after_rsp", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'b0, rsp_err}, 32'd0);
    check("rst_wren", {31'b0, mem_wren}, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    poke(4, 32'hDEADBEEF);
    run_req(1'b0, 32'h10, F3_W, '0, 0, lat, wrens, wcyc, rd, er);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", {31'b0, er}, 32'd0);
    check("lw_wren", 32'(wrens), 32'd0);

    poke(4, 32'h80FF0011);
    run_req(1'b0, 32'h13, F3_B, '0, 0, lat, wrens, wcyc, rd, er);
    check("lb_rdata", rd, 32'hFFFFFF80);
    check("lb_lat", 32'(lat), 32'd2);
    run_req(1'b0, 32'h13, F3_BU, '0, 0, lat, wrens, wcyc, rd, er);
    check("lbu_rdata", rd, 32'h00000080);
    run_req(1'b0, 32'h12, F3_H, '0, 0, lat, wrens, wcyc, rd, er);
    check("lh_rdata", rd, 32'hFFFF80FF);
    run_req(1'b0, 32'h10, F3_HU, '0, 0, lat, wrens, wcyc, rd, er);
    check("lhu_rdata", rd, 32'h00000011);

    poke(4, 32'h11223344);
    run_req(1'b1, 32'h11, F3_B, 32'h000000AB, 0, lat, wrens, wcyc, rd, er);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_wrens", 32'(wrens), 32'd1);
    check("sb_wcyc", 32'(wcyc), 32'd2);
    check("sb_mem", mem[4], 32'h1122AB44);
    check("sb_rdata", rd, 32'd0);
    check("sb_err", {31'b0, er}, 32'd0);
    run_req(1'b1, 32'h12, F3_H, 32'h0000BEEF, 0, lat, wrens, wcyc, rd, er);
    check("sh_mem", mem[4], 32'hBEEFAB44);
    check("sh_wrens", 32'(wrens), 32'd1);
    run_req(1'b1, 32'h20, F3_W, 32'h12345678, 0, lat, wrens, wcyc, rd, er);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_mem", mem[8], 32'h12345678);
    check("sw_wrens", 32'(wrens), 32'd1);
    check("sw_neighbour", mem[4], 32'hBEEFAB44);

    run_req(1'b0, 32'h02, F3_W, '0, 0, lat, wrens, wcyc, rd, er);
    check("lw_mis_err", {31'b0, er}, 32'd1);
    check("lw_mis_lat", 32'(lat), 32'd1);
    check("lw_mis_rdata", rd, 32'd0);
    run_req(1'b1, 32'h01, F3_H, 32'hFFFF, 0, lat, wrens, wcyc, rd, er);
    check("sh_mis_err", {31'b0, er}, 32'd1);
    check("sh_mis_lat", 32'(lat), 32'd1);
    check("sh_mis_wren", 32'(wrens), 32'd0);
    run_req(1'b0, 32'(4 * DEPTH), F3_W, '0, 0, lat, wrens, wcyc, rd, er);
    check("lw_oor_err", {31'b0, er}, 32'd1);
    check("lw_oor_lat", 32'(lat), 32'd1);
    check("lw_oor_rdata", rd, 32'd0);
    run_req(1'b0, 32'(4 * DEPTH - 4), F3_W, '0, 0, lat, wrens, wcyc, rd, er);
    check("lw_last_err", {31'b0, er}, 32'd0);
    run_req(1'b0, 32'h10, 3'b011, '0, 0, lat, wrens, wcyc, rd, er);
    check("f3_011_err", {31'b0, er}, 32'd1);
    run_req(1'b1, 32'h10, F3_BU, 32'h77, 0, lat, wrens, wcyc, rd, er);
    check("sbu_err", {31'b0, er}, 32'd1);
    check("sbu_wren", 32'(wrens), 32'd0);
    check("sbu_mem", mem[4], 32'hBEEFAB44);

    unstable = 0;
    run_req(1'b0, 32'h10, F3_W, '0, 5, lat, wrens, wcyc, rd, er);
    check("hold_rdata", rd, 32'hBEEFAB44);
    check("hold_stable", 32'(unstable), 32'd0);

    poke(4, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_f3 = F3_B; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rmw_wren_up", {31'b0, mem_wren}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rmw_rst_wren", {31'b0, mem_wren}, 32'd0);
    check("rmw_rst_ready", {31'b0, req_ready}, 32'd1);
    check("rmw_rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("rmw_rst_rdata", rsp_rdata, 32'd0);
    check("rmw_rst_err", {31'b0, rsp_err}, 32'd0);
    check("rmw_rst_addr", 32'(mem_addr), 32'd0);
    check("rmw_rst_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    check("rmw_rst_mem", mem[4], 32'h11223344);
    @(negedge clk) rst = 1'b0;

    run_req(1'b0, 32'h10, F3_W, '0, 0, lat, wrens, wcyc, rd, er);
    check("post_rst_lw", rd, 32'h11223344);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
